// File: rtl/reg_load_seq_pkg.sv
// Shared types for the register-bank write sequencer: FSM states and the queued request record.
// Addresses travel zero-extended to REQ_AW bits, so AW may not exceed REQ_AW.
package reg_load_seq_pkg;

    localparam int DATA_W = 8;
    localparam int REQ_AW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic [REQ_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/reg_load_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits, head visible combinationally.
// Latency: a push is visible at the head one cycle later; no push-to-pop bypass.
// Backpressure: full is registered-derived; pushes while full and pops while empty are dropped.
module reg_load_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/reg_load_seq.sv
// Write sequencer for a bank of active-low-enable octal registers; optional shadow readback (SHADOW_READBACK_EN).
// Latency: accept at T -> bus driven after T+1, enable low after T+2, capture at T+3; one write per 3 cycles.
// Backpressure: in_ready drops while the request FIFO is full; a same-cycle pop does not free a slot.
module reg_load_seq
    import reg_load_seq_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_oe,
    output logic [NREG-1:0]   reg_g_n,
    output logic              busy,
    output logic              wr_done,
    output logic              addr_err
`ifdef SHADOW_READBACK_EN
    ,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data
`endif
);

    state_t            state;
    state_t            state_nxt;
    req_t              push_req;
    req_t              head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_ok;
    logic [DATA_W-1:0] bus_data_nxt;
    logic              bus_oe_nxt;
    logic [NREG-1:0]   reg_g_n_nxt;
    logic              wr_done_nxt;
    logic              addr_err_nxt;

    assign in_ready      = !rst && !fifo_full;
    assign fifo_push     = in_valid && in_ready;
    assign push_req.addr = REQ_AW'(in_addr);
    assign push_req.data = in_data;

    // The head stays put through SETUP and STROBE; it is retired on the edge that ends STROBE.
    assign fifo_pop = (state == STROBE);
    assign head_ok  = (head.addr < REQ_AW'(NREG));
    assign busy     = (state != IDLE) || !fifo_empty;

    reg_load_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (push_req),
        .pop      (fifo_pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_nxt    = state;
        bus_data_nxt = bus_data;
        bus_oe_nxt   = bus_oe;
        reg_g_n_nxt  = '1;
        wr_done_nxt  = 1'b0;
        addr_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt    = SETUP;
                    bus_data_nxt = head.data;
                    bus_oe_nxt   = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                for (int i = 0; i < NREG; i++) begin
                    if (head.addr == REQ_AW'(i)) reg_g_n_nxt[i] = 1'b0;
                end
            end
            STROBE: begin
                state_nxt    = HOLD;
                wr_done_nxt  = head_ok;
                addr_err_nxt = !head_ok;
            end
            HOLD: begin
                // Data stays on the bus one cycle past the strobe before it may change.
                if (!fifo_empty) begin
                    state_nxt    = SETUP;
                    bus_data_nxt = head.data;
                end else begin
                    state_nxt  = IDLE;
                    bus_oe_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus_data <= '0;
            bus_oe   <= 1'b0;
            reg_g_n  <= '1;
            wr_done  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            bus_data <= bus_data_nxt;
            bus_oe   <= bus_oe_nxt;
            reg_g_n  <= reg_g_n_nxt;
            wr_done  <= wr_done_nxt;
            addr_err <= addr_err_nxt;
        end
    end

`ifdef SHADOW_READBACK_EN
    logic [DATA_W-1:0] shadow [2**AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) shadow[i] <= '0;
        end else if (state == STROBE && head_ok) begin
            shadow[head.addr[AW-1:0]] <= head.data;
        end
    end

    assign rb_data = ({1'b0, rb_addr} < (AW+1)'(NREG)) ? shadow[rb_addr] : '0;
`endif

endmodule
